vtpg_cfg_ctrl: RTL and testbench

Configuration and sequencing controller for the vtpg video timing pattern generator. It holds a shadow bank of the ten horizontal/vertical timing values, written over a simple valid/ready register port. It checks the values for correct ordering and commits them to the active bank that drives vtpg, applying the update only at a vertical-sync boundary so no frame is torn. It also gates vtpg through a run/enable reset and counts frames.

---
 rtl/vtpg_cfg_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_vtpg_cfg_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtpg_cfg_ctrl.sv
// rtl/vtpg_cfg_ctrl.sv - shadow/active timing bank, vsync-aligned commit and run sequencing for vtpg
// Shadow writes land immediately; the active bank only changes on a validated commit.
module vtpg_cfg_ctrl #(
    parameter int H_BITS    = 12,
    parameter int V_BITS    = 12,
    parameter int FCNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_addr,
    input  logic [15:0]          cfg_wdata,
    input  logic                 vs,
    output logic                 vtpg_rst_n,
    output logic [H_BITS-1:0]    tHS_START,
    output logic [H_BITS-1:0]    tHS_END,
    output logic [H_BITS-1:0]    tHACT_START,
    output logic [H_BITS-1:0]    tHACT_END,
    output logic [H_BITS-1:0]    tH_END,
    output logic [V_BITS-1:0]    tVS_START,
    output logic [V_BITS-1:0]    tVS_END,
    output logic [V_BITS-1:0]    tVACT_START,
    output logic [V_BITS-1:0]    tVACT_END,
    output logic [V_BITS-1:0]    tV_END,
    output logic                 cfg_done,
    output logic                 err_order,
    output logic                 running,
    output logic [FCNT_BITS-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_CTRL   = 4'd10;
    localparam logic [3:0] ADDR_COMMIT = 4'd11;

    localparam logic [H_BITS-1:0] H_RST [5] = '{H_BITS'(10), H_BITS'(20), H_BITS'(40),
                                                H_BITS'(50), H_BITS'(60)};
    localparam logic [V_BITS-1:0] V_RST [5] = '{V_BITS'(11), V_BITS'(21), V_BITS'(25),
                                                V_BITS'(35), V_BITS'(40)};

    state_t            state;
    logic [H_BITS-1:0] sh_h  [5];
    logic [V_BITS-1:0] sh_v  [5];
    logic [H_BITS-1:0] act_h [5];
    logic [V_BITS-1:0] act_v [5];
    logic              vs_q;
    logic              done_dly;

    logic              wr_en;
    logic              wr_h;
    logic              wr_v;
    logic              wr_ctrl;
    logic              wr_commit;
    logic [2:0]        h_idx;
    logic [2:0]        v_idx;
    logic [H_BITS-1:0] wd_h;
    logic [V_BITS-1:0] wd_v;
    logic              vs_rise;
    logic              order_ok;
    logic              unused_wdata;

    assign wr_en     = cfg_valid & cfg_ready;
    assign wr_h      = wr_en && (cfg_addr < 4'd5);
    assign wr_v      = wr_en && (cfg_addr >= 4'd5) && (cfg_addr < 4'd10);
    assign wr_ctrl   = wr_en && (cfg_addr == ADDR_CTRL);
    assign wr_commit = wr_en && (cfg_addr == ADDR_COMMIT);
    assign h_idx     = cfg_addr[2:0];
    assign v_idx     = 3'(cfg_addr - 4'd5);
    assign wd_h      = cfg_wdata[H_BITS-1:0];
    assign wd_v      = cfg_wdata[V_BITS-1:0];
    assign vs_rise   = vs & ~vs_q;
    assign unused_wdata = ^cfg_wdata;

    // Strictly increasing order across each group of five shadow values
    always_comb begin
        order_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (sh_h[i] >= sh_h[i+1]) order_ok = 1'b0;
            if (sh_v[i] >= sh_v[i+1]) order_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            cfg_ready  <= 1'b1;
            running    <= 1'b0;
            vtpg_rst_n <= 1'b0;
            cfg_done   <= 1'b0;
            done_dly   <= 1'b0;
            err_order  <= 1'b0;
            frame_cnt  <= '0;
            vs_q       <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                sh_h[i]  <= H_RST[i];
                act_h[i] <= H_RST[i];
                sh_v[i]  <= V_RST[i];
                act_v[i] <= V_RST[i];
            end
        end else begin
            vs_q       <= vs;
            vtpg_rst_n <= (state != S_OFF);
            done_dly   <= 1'b0;
            cfg_done   <= done_dly;

            if (running && vs_rise) frame_cnt <= frame_cnt + FCNT_BITS'(1);
            if (wr_h) sh_h[h_idx] <= wd_h;
            if (wr_v) sh_v[v_idx] <= wd_v;
            // Clear comes first so a same-cycle rejection below wins
            if (wr_ctrl && cfg_wdata[1]) err_order <= 1'b0;

            case (state)
                S_OFF: begin
                    if (wr_ctrl && cfg_wdata[0]) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                    if (wr_commit) begin
                        if (order_ok) begin
                            for (int i = 0; i < 5; i++) begin
                                act_h[i] <= sh_h[i];
                                act_v[i] <= sh_v[i];
                            end
                            done_dly <= 1'b1;
                        end else begin
                            err_order <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (wr_ctrl && !cfg_wdata[0]) begin
                        state   <= S_OFF;
                        running <= 1'b0;
                    end
                    if (wr_commit) begin
                        if (order_ok) begin
                            state     <= S_PEND;
                            cfg_ready <= 1'b0;
                        end else begin
                            err_order <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    // vs_q already reflects a vs edge seen at acceptance, so that edge cannot land here
                    if (vs_rise) begin
                        for (int i = 0; i < 5; i++) begin
                            act_h[i] <= sh_h[i];
                            act_v[i] <= sh_v[i];
                        end
                        cfg_done  <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                default: begin
                    state     <= S_OFF;
                    running   <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign tHS_START   = act_h[0];
    assign tHS_END     = act_h[1];
    assign tHACT_START = act_h[2];
    assign tHACT_END   = act_h[3];
    assign tH_END      = act_h[4];
    assign tVS_START   = act_v[0];
    assign tVS_END     = act_v[1];
    assign tVACT_START = act_v[2];
    assign tVACT_END   = act_v[3];
    assign tV_END      = act_v[4];

endmodule

// File: tb/tb_vtpg_cfg_ctrl.sv
// tb/tb_vtpg_cfg_ctrl.sv - randomized scenario bench for vtpg_cfg_ctrl
// Model keeps shadow/active banks as plain integer arrays updated per transaction.
module tb_vtpg_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        vs = 1'b0;
    logic        cfg_ready;
    logic        vtpg_rst_n;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic        cfg_done;
    logic        err_order;
    logic        running;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int rst_vals [10] = '{10, 20, 40, 50, 60, 11, 21, 25, 35, 40};
    int m_sh  [10];
    int m_act [10];
    int m_err;
    int m_fcnt;

    always #5 clk = ~clk;

    vtpg_cfg_ctrl #(.H_BITS(12), .V_BITS(12), .FCNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .vs(vs), .vtpg_rst_n(vtpg_rst_n),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .cfg_done(cfg_done), .err_order(err_order), .running(running), .frame_cnt(frame_cnt)
    );

    function automatic int dut_act(input int i);
        case (i)
            0: return int'(tHS_START);
            1: return int'(tHS_END);
            2: return int'(tHACT_START);
            3: return int'(tHACT_END);
            4: return int'(tH_END);
            5: return int'(tVS_START);
            6: return int'(tVS_END);
            7: return int'(tVACT_START);
            8: return int'(tVACT_END);
            default: return int'(tV_END);
        endcase
    endfunction

    function automatic bit model_order_ok();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 4; i++)
                if (m_sh[g*5+i] >= m_sh[g*5+i+1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_sh[i]  = rst_vals[i];
            m_act[i] = rst_vals[i];
        end
        m_err  = 0;
        m_fcnt = 0;
    endtask

    task automatic cfg_write(input int a, input int d);
        int n = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = 4'(a);
        cfg_wdata = 16'(d);
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            tests++; fails++;
            $display("FAIL cfg_write_timeout: addr %0d cfg_ready %0b required 1", a, cfg_ready);
            cfg_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        if (a < 10) m_sh[a] = d & 'hfff;
    endtask

    task automatic vs_pulse(input int hi, input int lo, inout int done_cnt);
        @(negedge clk);
        vs = 1'b1;
        repeat (hi) begin @(negedge clk); if (cfg_done) done_cnt++; end
        vs = 1'b0;
        repeat (lo) begin @(negedge clk); if (cfg_done) done_cnt++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        tests++; if (vtpg_rst_n !== 1'b0) begin fails++; $display("FAIL reset_vtpg_rst_n: got %0b want 0", vtpg_rst_n); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready); end
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL reset_cfg_done: got %0b want 0", cfg_done); end
        tests++; if (err_order !== 1'b0) begin fails++; $display("FAIL reset_err_order: got %0b want 0", err_order); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %0b want 0", running); end
        tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (dut_act(i) !== m_act[i]) begin fails++; $display("FAIL reset_active[%0d]: got %0d want %0d", i, dut_act(i), m_act[i]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_enable();
        int n = 3 + $urandom_range(0, 3);
        int dc = 0;
        cfg_write(10, 1);
        @(negedge clk);
        tests++; if (vtpg_rst_n !== 1'b0) begin fails++; $display("FAIL enable_vtpg_rst_n_early: got %0b want 0", vtpg_rst_n); end
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL enable_running: got %0b want 1", running); end
        @(negedge clk);
        tests++; if (vtpg_rst_n !== 1'b1) begin fails++; $display("FAIL enable_vtpg_rst_n: got %0b want 1", vtpg_rst_n); end
        repeat (n) vs_pulse($urandom_range(1, 3), $urandom_range(1, 3), dc);
        m_fcnt += n;
        tests++; if (frame_cnt !== 16'(m_fcnt)) begin fails++; $display("FAIL enable_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL enable_running_after_vs: got %0b want 1", running); end
        tests++; if (dc !== 0) begin fails++; $display("FAIL enable_spurious_done: got %0d want 0", dc); end
    endtask

    task automatic test_pending_commit();
        int new_hend = 61 + $urandom_range(0, 200);
        int seen = 0;
        int bad = 0;
        cfg_write(4, new_hend | ($urandom_range(0, 15) << 12));
        cfg_write(11, $urandom);
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL pend_cfg_ready: got %0b want 0", cfg_ready); end
        tests++; if (int'(tH_END) !== m_act[4]) begin fails++; $display("FAIL pend_hold_h_end: got %0d want %0d", tH_END, m_act[4]); end
        repeat ($urandom_range(2, 5)) begin
            @(negedge clk);
            if (cfg_done) seen++;
            if (int'(tH_END) !== m_act[4]) bad++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL pend_early_done: got %0d want 0", seen); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL pend_early_update: got %0d cycles changed want 0", bad); end
        vs = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) m_act[i] = m_sh[i];
        m_fcnt++;
        tests++; if (int'(tH_END) !== m_act[4]) begin fails++; $display("FAIL pend_land_h_end: got %0d want %0d", tH_END, m_act[4]); end
        tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL pend_done_pulse: got %0b want 1", cfg_done); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL pend_ready_back: got %0b want 1", cfg_ready); end
        vs = 1'b0;
        @(negedge clk);
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL pend_done_width: got %0b want 0", cfg_done); end
        tests++; if (frame_cnt !== 16'(m_fcnt)) begin fails++; $display("FAIL pend_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
    endtask

    task automatic test_commit_on_vs_edge();
        int seen = 0;
        int bad = 0;
        cfg_write(0, $urandom_range(0, 9));
        @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = 4'd11; cfg_wdata = 16'($urandom); vs = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        m_fcnt++;
        repeat (3) begin
            @(negedge clk);
            if (cfg_done) seen++;
            if (int'(tHS_START) !== m_act[0] || cfg_ready !== 1'b0) bad++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL vsedge_same_cycle_done: got %0d want 0", seen); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL vsedge_same_cycle_update: got %0d bad cycles want 0", bad); end
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) m_act[i] = m_sh[i];
        m_fcnt++;
        tests++; if (int'(tHS_START) !== m_act[0]) begin fails++; $display("FAIL vsedge_land: got %0d want %0d", tHS_START, m_act[0]); end
        tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL vsedge_done: got %0b want 1", cfg_done); end
        vs = 1'b0;
        @(negedge clk);
        tests++; if (frame_cnt !== 16'(m_fcnt)) begin fails++; $display("FAIL vsedge_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
    endtask

    task automatic test_order_err();
        int seen = 0;
        cfg_write(3, m_sh[4] + $urandom_range(0, 1));
        cfg_write(11, 0);
        m_err = 1;
        repeat (4) begin @(negedge clk); if (cfg_done) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL order_no_done: got %0d want 0", seen); end
        tests++; if (err_order !== 1'b1) begin fails++; $display("FAIL order_err_set: got %0b want 1", err_order); end
        tests++; if (running !== 1'b1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL order_stay_run: got running %0b ready %0b want 1 1", running, cfg_ready); end
        tests++; if (int'(tHACT_END) !== m_act[3]) begin fails++; $display("FAIL order_active_kept: got %0d want %0d", tHACT_END, m_act[3]); end
        cfg_write(10, 3);
        m_err = 0;
        @(negedge clk);
        tests++; if (err_order !== 1'b0) begin fails++; $display("FAIL order_err_clear: got %0b want 0", err_order); end
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL order_enable_again: got %0b want 1", running); end
        cfg_write(3, 50);
    endtask

    task automatic test_off_commit();
        int seen = 0;
        int dc = 0;
        cfg_write(10, 0);
        @(negedge clk);
        tests++; if (running !== 1'b0 || vtpg_rst_n !== 1'b1) begin fails++; $display("FAIL off_first_cycle: got running %0b vtpg_rst_n %0b want 0 1", running, vtpg_rst_n); end
        @(negedge clk);
        tests++; if (vtpg_rst_n !== 1'b0) begin fails++; $display("FAIL off_vtpg_rst_n: got %0b want 0", vtpg_rst_n); end
        cfg_write(5, 5);
        cfg_write(11, 0);
        for (int i = 0; i < 10; i++) m_act[i] = m_sh[i];
        for (int n = 0; n < 4 && seen == 0; n++) begin
            @(negedge clk);
            if (cfg_done) seen = 1;
        end
        tests++; if (seen !== 1) begin fails++; $display("FAIL off_done_seen: got %0d want 1", seen); end
        @(negedge clk);
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL off_done_width: got %0b want 0", cfg_done); end
        tests++; if (int'(tVS_START) !== 5) begin fails++; $display("FAIL off_vs_start: got %0d want 5", tVS_START); end
        repeat (2) vs_pulse(1, 2, dc);
        tests++; if (frame_cnt !== 16'(m_fcnt)) begin fails++; $display("FAIL off_frame_hold: got %0d want %0d", frame_cnt, m_fcnt); end
    endtask

    task automatic test_random_commits();
        for (int it = 0; it < 10; it++) begin
            int vals [10];
            int seen;
            bit ok;
            seen = 0;
            if (m_err != 0) begin cfg_write(10, 2); m_err = 0; end
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < 5; i++)
                    vals[g*5+i] = (i == 0) ? $urandom_range(0, 40) : vals[g*5+i-1] + $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 0) begin
                int g = $urandom_range(0, 1);
                int i = $urandom_range(0, 3);
                int t = vals[g*5+i];
                if ($urandom_range(0, 1) == 0) vals[g*5+i+1] = t;
                else begin vals[g*5+i] = vals[g*5+i+1]; vals[g*5+i+1] = t; end
            end
            for (int i = 0; i < 10; i++) cfg_write(i, vals[i] | ($urandom_range(0, 15) << 12));
            cfg_write($urandom_range(12, 15), $urandom);
            cfg_write(11, $urandom);
            ok = model_order_ok();
            if (ok) for (int i = 0; i < 10; i++) m_act[i] = m_sh[i];
            else m_err = 1;
            repeat (4) begin @(negedge clk); if (cfg_done) seen++; end
            tests++; if (seen !== (ok ? 1 : 0)) begin fails++; $display("FAIL rand_done[%0d]: got %0d want %0d", it, seen, ok ? 1 : 0); end
            tests++; if (int'(err_order) !== m_err) begin fails++; $display("FAIL rand_err[%0d]: got %0b want %0d", it, err_order, m_err); end
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (dut_act(i) !== m_act[i]) begin fails++; $display("FAIL rand_active[%0d][%0d]: got %0d want %0d", it, i, dut_act(i), m_act[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        int dc = 0;
        if (m_err != 0) begin cfg_write(10, 2); m_err = 0; end
        for (int i = 0; i < 10; i++) cfg_write(i, rst_vals[i]);
        cfg_write(10, 1);
        cfg_write(9, m_sh[9] + $urandom_range(1, 50));
        cfg_write(11, 0);
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL rstpend_in_pend: got ready %0b want 0", cfg_ready); end
        rst_n = 1'b0;
        #1;
        model_reset();
        tests++; if (vtpg_rst_n !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL rstpend_run_flags: got vtpg_rst_n %0b running %0b want 0 0", vtpg_rst_n, running); end
        tests++; if (cfg_ready !== 1'b1 || frame_cnt !== 16'd0) begin fails++; $display("FAIL rstpend_ready_cnt: got ready %0b frame_cnt %0d want 1 0", cfg_ready, frame_cnt); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (dut_act(i) !== m_act[i]) begin fails++; $display("FAIL rstpend_active[%0d]: got %0d want %0d", i, dut_act(i), m_act[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cfg_write(10, 1);
        repeat (3) vs_pulse($urandom_range(1, 2), $urandom_range(1, 2), dc);
        m_fcnt = 3;
        tests++; if (dc !== 0) begin fails++; $display("FAIL rstpend_no_done: got %0d want 0", dc); end
        tests++; if (int'(tV_END) !== m_act[9]) begin fails++; $display("FAIL rstpend_discard: got %0d want %0d", tV_END, m_act[9]); end
        tests++; if (frame_cnt !== 16'(m_fcnt)) begin fails++; $display("FAIL rstpend_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_pending_commit();
        test_commit_on_vs_edge();
        test_order_err();
        test_off_commit();
        test_random_commits();
        test_reset_mid_pend();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
